nibble_serial_adder_ctrl: RTL

Sequencer that adds two WIDTH-bit operands 4 bits per clock by reusing one 4-bit ripple-carry adder stage. The carry is held in a flop between steps.
- Sits between a requester (start/done handshake) and the shared 4-bit adder datapath.
- Trades latency for area versus a full-width combinational adder.

---
 rtl/nibble_add_pkg.sv | 18 +
 rtl/nibble_serial_adder_ctrl_if.sv | 39 +++
 rtl/nibble_add4.sv | 38 +++
 rtl/nibble_serial_adder_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder: state encoding,
// nibble width and the step-index width helper.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  // 2'd3 is unused; the controller treats it as a fault and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester-side bundle for the nibble-serial adder (start/done handshake).
// Optional sub/overflow signals exist only when SUB_MODE_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  // start is a request sampled only while idle or on the done cycle; done is a
  // one-cycle pulse marking sum/c_out valid, and they hold until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SUB_MODE_EN
  logic             sub;
  logic             overflow;
`endif

  modport master (
    output start, a, b, c_in,
`ifdef SUB_MODE_EN
    output sub,
    input  overflow,
`endif
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef SUB_MODE_EN
    input  sub,
    output overflow,
`endif
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from full_adder cells; also
// exposes the carry into bit 3 so the caller can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c_msb_in
);
  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (c[i]),
      .s     (s[i]),
      .c_out (c[i+1])
    );
  end

  assign c_out    = c[4];
  assign c_msb_in = c[3];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit adder. Define SUB_MODE_EN to add subtract mode and signed overflow.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nibble_serial_adder_ctrl_if.slave  bus,
  output state_t                     dbg_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);

  state_t            state, state_next;
  logic [WIDTH-1:0]  op_a, op_b, work, work_next, sum_q;
  logic [IDX_W-1:0]  idx;
  logic              carry, c_out_q;
  logic              accept, last_step;
  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [3:0]        stage_s;
  logic              stage_c_out, stage_c_msb;
`ifdef SUB_MODE_EN
  logic              overflow_q;
`endif

  assign accept    = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step = (idx == IDX_W'(NIBBLES - 1));

  // Shifting the current nibble down to bit 0 keeps the adder input mux
  // legal even when idx is a single unused bit (WIDTH=4).
  assign a_sh = op_a >> (NIBBLE_W * idx);
  assign b_sh = op_b >> (NIBBLE_W * idx);

  nibble_add4 u_add (
    .a        (a_sh[3:0]),
    .b        (b_sh[3:0]),
    .c_in     (carry),
    .s        (stage_s),
    .c_out    (stage_c_out),
    .c_msb_in (stage_c_msb)
  );

  always_comb begin
    work_next = work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) work_next[i*NIBBLE_W +: NIBBLE_W] = stage_s;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      work    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SUB_MODE_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        op_a <= bus.a;
        work <= '0;
        idx  <= '0;
`ifdef SUB_MODE_EN
        op_b  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub ? 1'b1 : bus.c_in;
`else
        op_b  <= bus.b;
        carry <= bus.c_in;
`endif
      end else if (state == ST_RUN) begin
        work  <= work_next;
        carry <= stage_c_out;
        idx   <= last_step ? '0 : idx + IDX_W'(1);
        if (last_step) begin
          sum_q   <= work_next;
          c_out_q <= stage_c_out;
`ifdef SUB_MODE_EN
          overflow_q <= stage_c_msb ^ stage_c_out;
`endif
        end
      end
    end
  end

`ifdef SUB_MODE_EN
  assign bus.overflow = overflow_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = stage_c_msb;
`endif

  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = (state == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign dbg_state = state;

endmodule
